// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its
// picker.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first request at or
// after ptr+1, wrapping modulo N.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      // ptr < N and k <= N, so a single subtraction is enough to wrap
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (cand == (IDX_W+1)'(i))) begin
          pick[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter granting whole bus cycles.
// Define WB_ARB_TIMEOUT_EN to add the stalled-cycle watchdog and FLUSH state.
//
// state | meaning
// IDLE  | no owner; pick next requester after ptr
// BUSY  | granted master drives the slave port
// FLUSH | watchdog fired; slave port parked until owner drops cyc
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS-1:0]                m_cyc,
  input  logic [NUM_MASTERS-1:0]                m_stb,
  input  logic [NUM_MASTERS-1:0]                m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel,
  output logic [DATA_WIDTH-1:0]                 m_rdata,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic [NUM_MASTERS-1:0]                m_err,
  output logic                                  s_cyc,
  output logic                                  s_stb,
  output logic                                  s_we,
  output logic [ADDR_WIDTH-1:0]                 s_addr,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [DATA_WIDTH/8-1:0]               s_sel,
  input  logic [DATA_WIDTH-1:0]                 s_rdata,
  input  logic                                  s_ack,
  input  logic                                  s_err,
  output logic [NUM_MASTERS-1:0]                grant,
  output logic                                  timeout
);

  localparam int SEL_W = DATA_WIDTH / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;
  logic                   owner_cyc;
  logic                   fire;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req  (m_cyc),
    .ptr  (ptr_q),
    .pick (pick)
  );

  assign grant_idx = onehot_to_idx(MAX_MASTERS'(grant_q));
  assign busy      = (state_q == BUSY);
  assign owner_cyc = |(m_cyc & grant_q);
  assign grant     = grant_q;
  assign m_rdata   = s_rdata;
  assign timeout   = fire;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (busy && grant_q[i]) begin
        s_cyc   = m_cyc[i];
        s_stb   = m_stb[i];
        s_we    = m_we[i];
        s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
      end
    end
    m_ack = busy ? (grant_q & {NUM_MASTERS{s_ack}}) : '0;
    m_err = busy ? (grant_q & {NUM_MASTERS{s_err | fire}}) : '0;
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        stall;

  assign stall = busy && s_stb && !s_ack && !s_err;
  // a termination in the expiry cycle suppresses the watchdog
  assign fire  = stall && owner_cyc && (cnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || s_ack || s_err) cnt_d = '0;
    else if (stall && !fire)               cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY, FLUSH: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = grant_idx;
        end else if (fire) begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 3'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table plus multi-cycle sequences.
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_sel;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ack, m_err;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_rdata;
  logic             s_ack, s_err;
  logic [NM-1:0]    grant;
  logic             timeout;

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_sel(m_sel), .m_rdata(m_rdata),
    .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_sel(s_sel), .s_rdata(s_rdata),
    .s_ack(s_ack), .s_err(s_err), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic        err;
    logic [1:0]  grant;
    logic        scyc;
    logic [1:0]  mack;
    logic [1:0]  merr;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err);
    @(negedge clk);
    m_cyc = cyc;
    m_stb = stb;
    s_ack = ack;
    s_err = err;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] model_wdata(input logic [1:0] g);
    case (g)
      2'b01:   return 32'hAAAA_0000;
      2'b10:   return 32'h5555_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input logic [1:0] g);
    case (g)
      2'b01:   return 4'h3;
      2'b10:   return 4'hC;
      default: return 4'h0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] g_seen;
    logic       ok;
    logic       saw_err;
    int         k;

    //          cyc    stb    ack   err   grant  scyc  mack   merr   addr
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[1]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 32'h1000};
    vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 32'h1000};
    vecs[4]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 32'h1000};
    vecs[5]  = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 32'h1000};
    vecs[6]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h1000};
    vecs[7]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[8]  = '{2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 32'h2000};
    vecs[9]  = '{2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, 32'h2000};
    vecs[10] = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 32'h2000};
    vecs[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 32'h1000};
    vecs[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 32'h1000};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0};

    m_addr  = {32'h0000_2000, 32'h0000_1000};
    m_wdata = {32'h5555_FFFF, 32'hAAAA_0000};
    m_sel   = {4'hC, 4'h3};
    m_we    = 2'b10;
    s_rdata = 32'hDEAD_BEEF;
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0;
    rst_n = 1'b0;

    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m_ack", m_ack, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rdata_bcast", m_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].err);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].grant);
      chk($sformatf("v%0d_s_cyc", i), s_cyc, vecs[i].scyc);
      chk($sformatf("v%0d_m_ack", i), m_ack, vecs[i].mack);
      chk($sformatf("v%0d_m_err", i), m_err, vecs[i].merr);
      chk($sformatf("v%0d_s_addr", i), s_addr, vecs[i].addr);
      chk($sformatf("v%0d_s_stb", i), s_stb, |(vecs[i].stb & vecs[i].grant));
      chk($sformatf("v%0d_s_we", i), s_we, |(m_we & vecs[i].grant));
      chk($sformatf("v%0d_s_wdata", i), s_wdata, model_wdata(vecs[i].grant));
      chk($sformatf("v%0d_s_sel", i), s_sel, model_sel(vecs[i].grant));
    end

    // simultaneous request from reset: master 0 first, one idle cycle, then master 1
    do_reset();
    drive(2'b11, 2'b11, 1'b0, 1'b0);
    chk("sim_idle0", grant, 2'b00);
    drive(2'b11, 2'b11, 1'b1, 1'b0);
    chk("sim_first", grant, 2'b01);
    chk("sim_ack0", m_ack, 2'b01);
    drive(2'b10, 2'b10, 1'b0, 1'b0);
    chk("sim_rel_scyc", s_cyc, 1'b0);
    drive(2'b10, 2'b10, 1'b0, 1'b0);
    chk("sim_bubble", grant, 2'b00);
    drive(2'b10, 2'b10, 1'b0, 1'b0);
    chk("sim_second", grant, 2'b10);
    chk("sim_second_addr", s_addr, 32'h2000);

    // continuous requests: six alternating grants
    do_reset();
    for (int g = 0; g < 6; g++) begin
      ok = 1'b0;
      for (int w = 0; w < 6 && !ok; w++) begin
        drive(2'b11, 2'b11, 1'b1, 1'b0);
        if (grant != 2'b00) ok = 1'b1;
      end
      chk($sformatf("alt%0d_wait", g), ok, 1'b1);
      g_seen = grant;
      chk($sformatf("alt%0d_grant", g), g_seen, (g % 2 == 0) ? 2'b01 : 2'b10);
      drive(2'b11 & ~g_seen, 2'b11 & ~g_seen, 1'b0, 1'b0);
    end

    // master 1 holds cyc across three beats; master 0 waits
    do_reset();
    drive(2'b10, 2'b00, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      drive(2'b11, 2'b11, 1'b0, 1'b0);
      chk($sformatf("hold%0d_grant", b), grant, 2'b10);
      drive(2'b11, 2'b11, 1'b1, 1'b0);
      chk($sformatf("hold%0d_ack_grant", b), grant, 2'b10);
      chk($sformatf("hold%0d_m_ack", b), m_ack, 2'b10);
    end
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    chk("hold_rel_grant", grant, 2'b10);
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    chk("hold_bubble", grant, 2'b00);
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    chk("hold_m0_served", grant, 2'b01);

    // stalled slave
    do_reset();
    drive(2'b01, 2'b01, 1'b0, 1'b0);
`ifdef WB_ARB_TIMEOUT_EN
    k = -1;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      drive(2'b01, 2'b01, 1'b0, 1'b0);
      if (s_stb) k++;
      if (m_err[0]) ok = 1'b1;
    end
    chk("to_fired", ok, 1'b1);
    chk("to_latency", k, 8);
    chk("to_pulse", timeout, 1'b1);
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    chk("to_pulse_end", timeout, 1'b0);
    chk("to_flush_scyc", s_cyc, 1'b0);
    chk("to_flush_merr", m_err, 2'b00);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    chk("to_back_idle", grant, 2'b00);
`else
    saw_err = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      drive(2'b01, 2'b01, 1'b0, 1'b0);
      if (timeout || m_err != 2'b00) saw_err = 1'b1;
    end
    chk("stall_no_timeout", saw_err, 1'b0);
    chk("stall_holds_bus", s_cyc, 1'b1);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    chk("stall_released", grant, 2'b00);
`endif

    // reset mid-transfer; master 0 served last so ptr would favour master 1 without reset
    do_reset();
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 2'b01, 1'b1, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    drive(2'b01, 2'b01, 1'b1, 1'b0);
    chk("mid_pre_ack", m_ack, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_s_cyc", s_cyc, 1'b0);
    chk("mid_grant", grant, 2'b00);
    chk("mid_m_ack", m_ack, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2'b11, 1'b0, 1'b0);
    drive(2'b11, 2'b11, 1'b0, 1'b0);
    chk("mid_after_grant", grant, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
